// File: rtl/cond_unit_pkg.sv
// Shared types and constants for the Execute-stage condition unit.
// Holds the ARM condition encoding, flag bit positions and the flag-merge helper.
package cond_unit_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000,
        NE = 4'b0001,
        CS = 4'b0010,
        CC = 4'b0011,
        MI = 4'b0100,
        PL = 4'b0101,
        VS = 4'b0110,
        VC = 4'b0111,
        HI = 4'b1000,
        LS = 4'b1001,
        GE = 4'b1010,
        LT = 4'b1011,
        GT = 4'b1100,
        LE = 4'b1101,
        AL = 4'b1110,
        NV = 4'b1111
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

    // N,Z and C,V are written independently so that logical ops can keep the carry.
    function automatic logic [3:0] merge_flags(input logic [3:0] old_flags,
                                               input logic [3:0] alu_flags,
                                               input logic [1:0] flag_write);
        logic [3:0] res;
        res = old_flags;
        if (flag_write[FW_NZ]) begin
            res[FLAG_N] = alu_flags[FLAG_N];
            res[FLAG_Z] = alu_flags[FLAG_Z];
        end
        if (flag_write[FW_CV]) begin
            res[FLAG_C] = alu_flags[FLAG_C];
            res[FLAG_V] = alu_flags[FLAG_V];
        end
        return res;
    endfunction

endpackage

// File: rtl/cond_unit_cond_check.sv
// Combinational ARM condition evaluator: condition code and {N,Z,C,V} in, pass out.
// Kept stateless so other conditional-execution logic can reuse it.
module cond_check
    import cond_unit_pkg::*;
(
    input  cond_t      cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign flag_n = flags[FLAG_N];
    assign flag_z = flags[FLAG_Z];
    assign flag_c = flags[FLAG_C];
    assign flag_v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            EQ: pass = flag_z;
            NE: pass = ~flag_z;
            CS: pass = flag_c;
            CC: pass = ~flag_c;
            MI: pass = flag_n;
            PL: pass = ~flag_n;
            VS: pass = flag_v;
            VC: pass = ~flag_v;
            HI: pass = flag_c & ~flag_z;
            LS: pass = ~flag_c | flag_z;
            GE: pass = (flag_n == flag_v);
            LT: pass = (flag_n != flag_v);
            GT: pass = ~flag_z & (flag_n == flag_v);
            LE: pass = flag_z | (flag_n != flag_v);
            AL: pass = 1'b1;
            NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Execute-stage condition unit: architectural flag register, condition gating of
// write/PC controls into the Memory stage, and a saturating condition-fail counter.
module cond_unit
    import cond_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic             StallE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic [3:0]       ALUFlagsE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic             PCSE,
    input  logic             BranchE,
    input  logic             FlushM,
    input  logic             CntClr,
    output logic             CondExE,
    output logic [3:0]       FlagsQ,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic             PCSrcM,
    output logic [CNT_W-1:0] FailCount
);

    if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
        $error("cond_unit: CNT_W must be within 4..32");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    cond_t            cond_e;
    logic             cond_pass;
    logic             consume_e;
    logic             take_e;
    logic             fail_e;

    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic             reg_write_m_q;
    logic             reg_write_m_d;
    logic             mem_write_m_q;
    logic             mem_write_m_d;
    logic             pc_src_m_q;
    logic             pc_src_m_d;
    logic [CNT_W-1:0] fail_cnt_q;
    logic [CNT_W-1:0] fail_cnt_d;

    assign cond_e = cond_t'(CondE);

    // Evaluated against the registered flags only; no forwarding from ALUFlagsE.
    cond_check u_cond_check (
        .cond  (cond_e),
        .flags (flags_q),
        .pass  (cond_pass)
    );

    assign consume_e = ValidE & ~StallE;
    assign take_e    = consume_e & cond_pass;
    assign fail_e    = consume_e & ~cond_pass;

    always_comb begin
        flags_d = flags_q;
        if (take_e) begin
            flags_d = merge_flags(flags_q, ALUFlagsE, FlagWriteE);
        end
    end

    // Flush wins over everything; a non-taken instruction becomes a bubble in M.
    always_comb begin
        reg_write_m_d = 1'b0;
        mem_write_m_d = 1'b0;
        pc_src_m_d    = 1'b0;
        if (!FlushM && take_e) begin
            reg_write_m_d = RegWriteE;
            mem_write_m_d = MemWriteE;
            pc_src_m_d    = PCSE | BranchE;
        end
    end

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (CntClr) begin
            fail_cnt_d = '0;
        end else if (fail_e && (fail_cnt_q != CNT_MAX)) begin
            fail_cnt_d = fail_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q       <= 4'b0000;
            reg_write_m_q <= 1'b0;
            mem_write_m_q <= 1'b0;
            pc_src_m_q    <= 1'b0;
            fail_cnt_q    <= '0;
        end else begin
            flags_q       <= flags_d;
            reg_write_m_q <= reg_write_m_d;
            mem_write_m_q <= mem_write_m_d;
            pc_src_m_q    <= pc_src_m_d;
            fail_cnt_q    <= fail_cnt_d;
        end
    end

    assign CondExE   = cond_pass;
    assign FlagsQ    = flags_q;
    assign RegWriteM = reg_write_m_q;
    assign MemWriteM = mem_write_m_q;
    assign PCSrcM    = pc_src_m_q;
    assign FailCount = fail_cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: stimulus pushes expected responses, a negedge
// monitor pops and compares them; a few hand-valued spot checks are made directly.
module tb_cond_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ValidE, StallE, RegWriteE, MemWriteE, PCSE, BranchE, FlushM, CntClr;
    logic [3:0]       CondE, ALUFlagsE;
    logic [1:0]       FlagWriteE;
    logic             CondExE, RegWriteM, MemWriteM, PCSrcM;
    logic [3:0]       FlagsQ;
    logic [CNT_W-1:0] FailCount;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .ValidE     (ValidE),
        .StallE     (StallE),
        .CondE      (CondE),
        .FlagWriteE (FlagWriteE),
        .ALUFlagsE  (ALUFlagsE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .PCSE       (PCSE),
        .BranchE    (BranchE),
        .FlushM     (FlushM),
        .CntClr     (CntClr),
        .CondExE    (CondExE),
        .FlagsQ     (FlagsQ),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .PCSrcM     (PCSrcM),
        .FailCount  (FailCount)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         comb;
        logic       cx;
        logic [3:0] fl;
        logic       rw, mw, pc;
        logic [3:0] cnt;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [3:0] m_flags;
    logic [3:0] m_cnt;

    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL %s: entry for cycle %0d seen at cycle %0d", e.tag, e.cyc, cyc);
            end else if (e.comb) begin
                if (CondExE !== e.cx) begin
                    n_err++;
                    $display("FAIL %s CondExE: got %b want %b", e.tag, CondExE, e.cx);
                end
            end else if (FlagsQ !== e.fl || RegWriteM !== e.rw || MemWriteM !== e.mw ||
                         PCSrcM !== e.pc || FailCount !== e.cnt) begin
                n_err++;
                $display("FAIL %s regs: got fl=%b rw=%b mw=%b pc=%b cnt=%h want fl=%b rw=%b mw=%b pc=%b cnt=%h",
                         e.tag, FlagsQ, RegWriteM, MemWriteM, PCSrcM, FailCount,
                         e.fl, e.rw, e.mw, e.pc, e.cnt);
            end
        end
    end

    task automatic idle();
        ValidE = 0; StallE = 0; CondE = 4'hE; FlagWriteE = 0; ALUFlagsE = 0;
        RegWriteE = 0; MemWriteE = 0; PCSE = 0; BranchE = 0; FlushM = 0; CntClr = 0;
    endtask

    // Called at posedge+1; drives one Execute cycle and returns at the next posedge+1.
    task automatic apply(input string tag, input logic v, input logic s, input logic [3:0] c,
                         input logic [1:0] fw, input logic [3:0] alu, input logic rw,
                         input logic mw, input logic pcs, input logic br, input logic fl,
                         input logic clr);
        exp_t ec, er;
        logic cx, take, fail;
        ValidE = v; StallE = s; CondE = c; FlagWriteE = fw; ALUFlagsE = alu;
        RegWriteE = rw; MemWriteE = mw; PCSE = pcs; BranchE = br; FlushM = fl; CntClr = clr;
        cx   = ref_cond(c, m_flags);
        take = v && !s && cx;
        fail = v && !s && !cx;
        ec = '{cyc: cyc, comb: 1'b1, cx: cx, fl: 4'h0, rw: 1'b0, mw: 1'b0, pc: 1'b0, cnt: 4'h0, tag: tag};
        q.push_back(ec);
        if (take) begin
            if (fw[1]) m_flags[3:2] = alu[3:2];
            if (fw[0]) m_flags[1:0] = alu[1:0];
        end
        if (clr) m_cnt = 4'h0;
        else if (fail && m_cnt != 4'hF) m_cnt = m_cnt + 4'h1;
        er = '{cyc: cyc + 1, comb: 1'b0, cx: 1'b0, fl: m_flags,
               rw: take && !fl && rw, mw: take && !fl && mw, pc: take && !fl && (pcs || br),
               cnt: m_cnt, tag: tag};
        q.push_back(er);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1'b1;
        m_flags = 4'h0;
        m_cnt   = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {FlagsQ, RegWriteM, MemWriteM, PCSrcM, FailCount}, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //         tag          v  s  cond   fw     alu     rw mw pcs br fl clr
        apply("eq_after_rst", 1, 0, 4'h0, 2'b00, 4'h0,   1, 0, 0,  0, 0, 0);
        chk("eq_fail_cnt", FailCount, 1);
        chk("eq_fail_rw", RegWriteM, 0);
        apply("subs_al",      1, 0, 4'hE, 2'b11, 4'b0100, 1, 0, 0,  0, 0, 0);
        chk("subs_flags", FlagsQ, 4'b0100);
        chk("subs_rw", RegWriteM, 1);
        apply("beq_taken",    1, 0, 4'h0, 2'b00, 4'h0,   0, 0, 0,  1, 0, 0);
        chk("beq_pcsrc", PCSrcM, 1);
        apply("nz_only",      1, 0, 4'hE, 2'b10, 4'b1011, 0, 0, 0,  0, 0, 0);
        chk("nz_only_flags", FlagsQ, 4'b1000);
        apply("stall_set",    1, 1, 4'hE, 2'b11, 4'b0110, 1, 0, 0,  0, 0, 0);
        chk("stall_flags", FlagsQ, 4'b1000);
        chk("stall_rw", RegWriteM, 0);
        apply("stall_nv",     1, 1, 4'hF, 2'b00, 4'h0,   0, 0, 0,  0, 0, 0);
        chk("stall_cnt", FailCount, 1);
        apply("unstall_set",  1, 0, 4'hE, 2'b11, 4'b0110, 1, 0, 0,  0, 0, 0);
        chk("unstall_flags", FlagsQ, 4'b0110);
        apply("flush_set",    1, 0, 4'hE, 2'b11, 4'b0001, 1, 1, 1,  0, 1, 0);
        chk("flush_flags", FlagsQ, 4'b0001);
        apply("vs_mem",       1, 0, 4'h6, 2'b00, 4'h0,   0, 1, 1,  0, 0, 0);
        chk("vs_mem_mw", MemWriteM, 1);
        apply("cs_fail",      1, 0, 4'h2, 2'b11, 4'hF,   1, 1, 1,  1, 0, 0);
        chk("cs_fail_flags", FlagsQ, 4'b0001);

        for (int f = 0; f < 16; f++) begin
            apply($sformatf("set_f%0d", f), 1, 0, 4'hE, 2'b11, 4'(f), 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                apply($sformatf("sweep_f%0d_c%0d", f, c), 0, 0, 4'(c), 2'b11, ~4'(f),
                      1, 1, 1, 1, 0, 0);
            end
        end

        apply("clr_fail",     1, 0, 4'hF, 2'b00, 4'h0,   1, 0, 0,  0, 0, 1);
        chk("clr_cnt", FailCount, 0);
        for (int i = 0; i < 20; i++) begin
            apply($sformatf("nv_%0d", i), 1, 0, 4'hF, 2'b11, 4'hA, 1, 1, 1, 1, 0, 0);
        end
        chk("sat_cnt", FailCount, 4'hF);
        apply("clr_sat",      1, 0, 4'hF, 2'b00, 4'h0,   0, 0, 0,  0, 0, 1);
        chk("clr_sat_cnt", FailCount, 0);
        apply("nv_post_clr",  1, 0, 4'hF, 2'b00, 4'h0,   0, 0, 0,  0, 0, 0);
        apply("set_all",      1, 0, 4'hE, 2'b11, 4'hF,   0, 0, 0,  1, 0, 0);
        idle();
        @(negedge clk);
        #1;
        chk("pre_rst_flags", FlagsQ, 4'hF);
        chk("pre_rst_pcsrc", PCSrcM, 1);
        reset = 1'b1;
        #1;
        chk("async_rst", {FlagsQ, PCSrcM, FailCount}, 32'h0);
        #1;
        reset = 1'b0;
        m_flags = 4'h0;
        m_cnt   = 4'h0;
        @(posedge clk);
        #1;
        apply("post_rst_eq",  1, 0, 4'h0, 2'b00, 4'h0,   1, 0, 0,  0, 0, 0);
        apply("post_rst_set", 1, 0, 4'hE, 2'b01, 4'b1111, 1, 0, 1, 0, 0, 0);
        chk("post_rst_flags", FlagsQ, 4'b0011);
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Execute-stage condition unit; consumes the 4-bit {N,Z,C,V} flags produced by the ALU.
- Holds the architectural flag register and evaluates the instruction's 4-bit ARM condition field against it.
- Gates register write, memory write and PC-source for a failed condition, then registers the gated controls into the Memory stage.
- Keeps a saturating count of condition-failed instructions for debug/performance readout.

Parameters:
CNT_W, 16, width of the condition-failed counter (legal 4..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ValidE  input  1  instruction in Execute is real (0 = bubble/flushed)
StallE  input  1  Execute stage held this cycle; instruction not consumed
CondE  input  4  condition field of the Execute instruction
FlagWriteE  input  2  [1] = update N,Z; [0] = update C,V
ALUFlagsE  input  4  ALU flags {N,Z,C,V} of the Execute instruction
RegWriteE  input  1  Execute instruction writes register file
MemWriteE  input  1  Execute instruction writes memory
PCSE  input  1  Execute instruction writes PC (non-branch)
BranchE  input  1  Execute instruction is a branch
FlushM  input  1  synchronous clear of Memory-stage control outputs
CntClr  input  1  synchronous clear of fail counter
CondExE  output  1  combinational: condition passes for the Execute instruction
FlagsQ  output  4  current flag register {N,Z,C,V}
RegWriteM  output  1  registered, gated register write
MemWriteM  output  1  registered, gated memory write
PCSrcM  output  1  registered, gated (PCSE | BranchE)
FailCount  output  CNT_W  saturating count of condition-failed instructions

Behaviour:
- Reset (async, reset=1): FlagsQ=4'b0000, RegWriteM=MemWriteM=PCSrcM=0, FailCount=0. Reset released mid-stream: first edge after release behaves as a normal cycle.
- Define Take = ValidE & ~StallE & CondExE.
- CondExE is combinational from CondE and FlagsQ only; ALUFlagsE never affects it.
- Condition table:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Flag register update at the clock edge when Take=1:
  - FlagWriteE[1]=1: N,Z <= ALUFlagsE[3:2].
  - FlagWriteE[0]=1: C,V <= ALUFlagsE[1:0].
  - The two halves are independent. No update when Take=0.
- Back-to-back flag-setting then dependent instruction: the flags written at edge k are visible to CondExE in cycle k+1. Latency 1, no forwarding path needed.
- M-stage registers, each edge, in priority order:
  - FlushM=1: all three outputs <= 0.
  - else if Take=0 (bubble, stall or failed condition): all <= 0.
  - else RegWriteM<=RegWriteE, MemWriteM<=MemWriteE, PCSrcM<=PCSE|BranchE.
- Stall: flags and FailCount are frozen and a bubble enters M. The held instruction re-evaluates next cycle against unchanged flags.
- FailCount update:
  - CntClr=1: FailCount <= 0, taking priority over increment.
  - else increments when ValidE & ~StallE & ~CondExE.
  - Saturates at all-ones, with no wrap.
  - NV (1111) instructions count as failed.
- FlushM does not affect flags or FailCount; the Execute instruction's flag write still occurs if Take=1.

Decomposition:
- Shared package: typedef enum logic [3:0] cond_t (EQ..NV); flag bit-index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0; FlagWrite bit constants FW_NZ=1, FW_CV=0.
- One sub-module, cond_check: purely combinational (cond_t, flags) -> pass. Reused by any future conditional-execution logic.
- Flag register, M-stage registers and counter stay in cond_unit.

Test Plan:
- Reset then CondE=EQ, ValidE=1 -> CondExE=0 (Z=0); RegWriteE=1 gives RegWriteM=0 next cycle and FailCount=1.
- SUBS setting ALUFlagsE=4'b0100 with FlagWriteE=2'b11, AL -> next cycle FlagsQ=4'b0100; following BEQ with BranchE=1 -> PCSrcM=1 one cycle later.
- FlagWriteE=2'b10 with ALUFlagsE=4'b1011 from FlagsQ=4'b0100 -> FlagsQ=4'b1000 (C,V unchanged).
- Sweep all 16 CondE codes over all 16 FlagsQ values -> CondExE matches the table; NV always 0.
- StallE=1 with a passing flag-setting instruction -> FlagsQ unchanged, M outputs 0, FailCount unchanged; deassert StallE -> update occurs.
- FailCount saturation with CNT_W=4: 20 failed instructions -> FailCount=4'hF. CntClr together with a failing instruction -> FailCount=0.
- Reset asserted mid-stream with FlagsQ=4'b1111 and PCSrcM=1 -> FlagsQ=0 and PCSrcM=0 immediately, without waiting for a clock edge.
